obi_rr_scheduler: RTL and testbench

OBI_RR_SCHEDULER -- requirements
Module: obi_rr_scheduler

---
 rtl/obi_sched_pkg.sv | 24 ++
 rtl/obi_owner_fifo.sv | 72 +++++++
 rtl/obi_rr_scheduler.sv | 144 ++++++++++++++
 tb/tb_obi_rr_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_sched_pkg.sv
// Shared types and constants for the two-slave OBI round-robin scheduler.
// Owner IDs, error-cause bit positions and the round-robin pick helper.
package obi_sched_pkg;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

    localparam int unsigned ERR_SPURIOUS_RVALID = 0;
    localparam int unsigned ERR_REQ_WITHDRAWN   = 1;
    localparam int unsigned ERR_NUM             = 2;

    // On a contest, the winner is whichever slave was not granted last.
    function automatic owner_e rr_pick(input logic req_a, input logic req_b, input owner_e last);
        if (req_a && req_b) begin
            return (last == OWNER_B) ? OWNER_A : OWNER_B;
        end else if (req_b) begin
            return OWNER_B;
        end
        return OWNER_A;
    endfunction

endpackage

// File: rtl/obi_owner_fifo.sv
// In-order FIFO of transaction owners; one entry per accepted address phase.
// Pointers wrap naturally because DEPTH is a power of two.
module obi_owner_fifo
    import obi_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     data_i,
    input  logic                     pop_i,
    output logic                     data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/obi_rr_scheduler.sv
// Round-robin OBI arbiter merging slave A (VPU) and slave B (CPU) onto one master port,
// with in-order response routing through an owner FIFO.
module obi_rr_scheduler
    import obi_sched_pkg::*;
#(
    parameter int unsigned NUM_OUTSTANDING = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               s_req_a_i,
    input  logic [ADDR_WIDTH-1:0]              s_addr_a_i,
    input  logic [DATA_WIDTH/8-1:0]            s_be_a_i,
    input  logic                               s_we_a_i,
    input  logic [DATA_WIDTH-1:0]              s_wdata_a_i,
    output logic                               s_gnt_a_o,
    output logic                               s_rvalid_a_o,
    output logic [DATA_WIDTH-1:0]              s_rdata_a_o,
    input  logic                               s_req_b_i,
    input  logic [ADDR_WIDTH-1:0]              s_addr_b_i,
    input  logic [DATA_WIDTH/8-1:0]            s_be_b_i,
    input  logic                               s_we_b_i,
    input  logic [DATA_WIDTH-1:0]              s_wdata_b_i,
    output logic                               s_gnt_b_o,
    output logic                               s_rvalid_b_o,
    output logic [DATA_WIDTH-1:0]              s_rdata_b_o,
    output logic                               m_req_o,
    output logic [ADDR_WIDTH-1:0]              m_addr_o,
    output logic [DATA_WIDTH/8-1:0]            m_be_o,
    output logic                               m_we_o,
    output logic [DATA_WIDTH-1:0]              m_wdata_o,
    input  logic                               m_gnt_i,
    input  logic                               m_rvalid_i,
    input  logic [DATA_WIDTH-1:0]              m_rdata_i,
    output logic [$clog2(NUM_OUTSTANDING):0]   outstanding_o,
    output logic                               err_o
);

    owner_e               last_gnt_q, last_gnt_d;
    logic                 lock_q, lock_d;
    owner_e               lock_owner_q, lock_owner_d;
    logic [ERR_NUM-1:0]   err_q, err_d;

    owner_e               sel;
    logic                 sel_valid;
    logic                 withdrawn;
    logic                 handshake;
    logic                 fifo_full, fifo_empty, fifo_head;
    logic                 rsp_pop;

    obi_owner_fifo #(
        .DEPTH (NUM_OUTSTANDING)
    ) u_owner_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (handshake),
        .data_i  (sel),
        .pop_i   (rsp_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

    // A locked owner keeps the port; if it withdraws, the lock is dropped and arbitration reruns.
    always_comb begin
        sel       = OWNER_A;
        sel_valid = 1'b0;
        withdrawn = 1'b0;
        if (lock_q) begin
            if ((lock_owner_q == OWNER_A) ? s_req_a_i : s_req_b_i) begin
                sel       = lock_owner_q;
                sel_valid = 1'b1;
            end else begin
                withdrawn = 1'b1;
            end
        end
        if (!sel_valid) begin
            sel       = rr_pick(s_req_a_i, s_req_b_i, last_gnt_q);
            sel_valid = s_req_a_i || s_req_b_i;
        end
    end

    assign m_req_o   = sel_valid && !fifo_full;
    assign handshake = m_req_o && m_gnt_i;
    assign s_gnt_a_o = handshake && (sel == OWNER_A);
    assign s_gnt_b_o = handshake && (sel == OWNER_B);

    always_comb begin
        m_addr_o  = '0;
        m_be_o    = '0;
        m_we_o    = 1'b0;
        m_wdata_o = '0;
        if (m_req_o) begin
            if (sel == OWNER_A) begin
                m_addr_o  = s_addr_a_i;
                m_be_o    = s_be_a_i;
                m_we_o    = s_we_a_i;
                m_wdata_o = s_wdata_a_i;
            end else begin
                m_addr_o  = s_addr_b_i;
                m_be_o    = s_be_b_i;
                m_we_o    = s_we_b_i;
                m_wdata_o = s_wdata_b_i;
            end
        end
    end

    assign rsp_pop      = m_rvalid_i && !fifo_empty;
    assign s_rvalid_a_o = rsp_pop && (owner_e'(fifo_head) == OWNER_A);
    assign s_rvalid_b_o = rsp_pop && (owner_e'(fifo_head) == OWNER_B);
    assign s_rdata_a_o  = m_rdata_i;
    assign s_rdata_b_o  = m_rdata_i;
    assign err_o        = |err_q;

    always_comb begin
        lock_d       = m_req_o && !m_gnt_i;
        lock_owner_d = m_req_o ? sel : lock_owner_q;
        last_gnt_d   = handshake ? sel : last_gnt_q;
        err_d        = err_q;
        if (m_rvalid_i && fifo_empty) begin
            err_d[ERR_SPURIOUS_RVALID] = 1'b1;
        end
        if (withdrawn) begin
            err_d[ERR_REQ_WITHDRAWN] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_gnt_q   <= OWNER_B;
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_A;
            err_q        <= '0;
        end else begin
            last_gnt_q   <= last_gnt_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_obi_rr_scheduler.sv
// Directed bench for obi_rr_scheduler: alternation, lock, full, push+pop, spurious
// response, withdrawn request and mid-operation reset.
module tb_obi_rr_scheduler;

    localparam int unsigned NO = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          req_a, we_a, req_b, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [3:0]    be_a, be_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          gnt_a, rvalid_a, gnt_b, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          m_req, m_we, m_gnt, m_rvalid;
    logic [AW-1:0] m_addr;
    logic [3:0]    m_be;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [2:0]    outstanding;
    logic          err;

    int checks = 0;
    int errors = 0;

    obi_rr_scheduler #(
        .NUM_OUTSTANDING (NO),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .s_req_a_i     (req_a),
        .s_addr_a_i    (addr_a),
        .s_be_a_i      (be_a),
        .s_we_a_i      (we_a),
        .s_wdata_a_i   (wdata_a),
        .s_gnt_a_o     (gnt_a),
        .s_rvalid_a_o  (rvalid_a),
        .s_rdata_a_o   (rdata_a),
        .s_req_b_i     (req_b),
        .s_addr_b_i    (addr_b),
        .s_be_b_i      (be_b),
        .s_we_b_i      (we_b),
        .s_wdata_b_i   (wdata_b),
        .s_gnt_b_o     (gnt_b),
        .s_rvalid_b_o  (rvalid_b),
        .s_rdata_b_o   (rdata_b),
        .m_req_o       (m_req),
        .m_addr_o      (m_addr),
        .m_be_o        (m_be),
        .m_we_o        (m_we),
        .m_wdata_o     (m_wdata),
        .m_gnt_i       (m_gnt),
        .m_rvalid_i    (m_rvalid),
        .m_rdata_i     (m_rdata),
        .outstanding_o (outstanding),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks run 1ns after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_a = 0; req_b = 0; m_gnt = 0; m_rvalid = 0; m_rdata = '0;
        addr_a = 32'hA0; be_a = 4'hF; we_a = 1'b1; wdata_a = 32'hDA;
        addr_b = 32'hB0; be_b = 4'h3; we_b = 1'b0; wdata_b = 32'hDB;
        #2;
        chk("rst_m_req", m_req, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err, 0);
        chk("rst_m_addr", m_addr, 0);
        tick();
        rst = 1'b0;

        // Alternation: A, B, A, B with responses one cycle behind
        req_a = 1; req_b = 1; m_gnt = 1;
        settle();
        chk("alt1_gnt_a", gnt_a, 1);
        chk("alt1_gnt_b", gnt_b, 0);
        chk("alt1_addr", m_addr, 32'hA0);
        chk("alt1_we", m_we, 1);
        chk("alt1_be", m_be, 4'hF);
        tick();
        m_rvalid = 1; m_rdata = 32'h111;
        settle();
        chk("alt2_gnt_b", gnt_b, 1);
        chk("alt2_addr", m_addr, 32'hB0);
        chk("alt2_be", m_be, 4'h3);
        chk("alt2_rvalid_a", rvalid_a, 1);
        chk("alt2_rvalid_b", rvalid_b, 0);
        chk("alt2_rdata_a", rdata_a, 32'h111);
        tick();
        m_rdata = 32'h222;
        settle();
        chk("alt3_gnt_a", gnt_a, 1);
        chk("alt3_rvalid_b", rvalid_b, 1);
        chk("alt3_rvalid_a", rvalid_a, 0);
        chk("alt3_rdata_b", rdata_b, 32'h222);
        chk("alt3_outstanding", outstanding, 1);
        tick();
        m_rdata = 32'h333;
        settle();
        chk("alt4_gnt_b", gnt_b, 1);
        chk("alt4_rvalid_a", rvalid_a, 1);
        tick();
        req_a = 0; req_b = 0; m_rdata = 32'h444;
        settle();
        chk("alt5_m_req", m_req, 0);
        chk("alt5_rvalid_b", rvalid_b, 1);
        tick();
        m_rvalid = 0;
        settle();
        chk("alt_drained", outstanding, 0);

        // Lock: address held through three stalled cycles
        addr_a = 32'hA4; addr_b = 32'hB4;
        req_a = 1; req_b = 1; m_gnt = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("lock_m_req", m_req, 1);
            chk("lock_addr", m_addr, 32'hA4);
            chk("lock_no_gnt_a", gnt_a, 0);
            tick();
        end
        m_gnt = 1;
        settle();
        chk("lock_gnt_a", gnt_a, 1);
        chk("lock_addr_at_gnt", m_addr, 32'hA4);
        tick();
        settle();
        chk("lock_then_gnt_b", gnt_b, 1);
        chk("lock_then_addr_b", m_addr, 32'hB4);
        tick();

        // Push and pop together at count 2: owners [A,B] -> [B,A]
        req_b = 0; m_rvalid = 1; m_rdata = 32'h555;
        settle();
        chk("pp_count_before", outstanding, 2);
        chk("pp_gnt_a", gnt_a, 1);
        chk("pp_rvalid_a", rvalid_a, 1);
        chk("pp_rvalid_b", rvalid_b, 0);
        tick();
        req_a = 0;
        settle();
        chk("pp_count_after", outstanding, 2);
        chk("pp_head_b", rvalid_b, 1);
        tick();
        settle();
        chk("pp_tail_a", rvalid_a, 1);
        tick();
        m_rvalid = 0;
        settle();
        chk("pp_drained", outstanding, 0);

        // Full: four grants, then blocked even while a response pops
        req_a = 1; m_gnt = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("full_fill_gnt_a", gnt_a, 1);
            tick();
        end
        settle();
        chk("full_outstanding", outstanding, 4);
        chk("full_m_req", m_req, 0);
        chk("full_gnt_a", gnt_a, 0);
        m_rvalid = 1;
        settle();
        chk("full_pop_m_req", m_req, 0);
        chk("full_pop_rvalid_a", rvalid_a, 1);
        tick();
        m_rvalid = 0;
        settle();
        chk("full_after_pop_count", outstanding, 3);
        chk("full_after_pop_m_req", m_req, 1);
        tick();
        req_a = 0; m_rvalid = 1;
        settle();
        chk("full_refill_count", outstanding, 4);
        tick();
        m_rvalid = 0;
        settle();
        chk("pre_rst_count", outstanding, 3);

        // Reset with three in flight; A must win the next contest
        rst = 1;
        settle();
        chk("midrst_outstanding", outstanding, 0);
        chk("midrst_m_req", m_req, 0);
        chk("midrst_rvalid_a", rvalid_a, 0);
        tick();
        rst = 0;
        req_a = 1; req_b = 1; m_gnt = 1;
        settle();
        chk("postrst_gnt_a", gnt_a, 1);
        chk("postrst_gnt_b", gnt_b, 0);
        tick();
        req_a = 0; req_b = 0; m_rvalid = 1;
        settle();
        chk("postrst_rvalid_a", rvalid_a, 1);
        tick();

        // Spurious response with nothing in flight
        settle();
        chk("spur_count", outstanding, 0);
        chk("spur_rvalid_a", rvalid_a, 0);
        chk("spur_rvalid_b", rvalid_b, 0);
        chk("spur_err_before", err, 0);
        tick();
        m_rvalid = 0;
        settle();
        chk("spur_err_set", err, 1);
        tick();
        tick();
        settle();
        chk("spur_err_sticky", err, 1);
        rst = 1;
        settle();
        chk("spur_err_cleared", err, 0);
        tick();
        rst = 0;

        // Withdrawn request while stalled
        req_b = 1; m_gnt = 0;
        settle();
        chk("wd_m_req", m_req, 1);
        chk("wd_addr_b", m_addr, 32'hB4);
        tick();
        chk("wd_err_before", err, 0);
        req_b = 0;
        tick();
        settle();
        chk("wd_err_set", err, 1);
        chk("wd_m_req_idle", m_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
